// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal around mem_port_arbiter: the instruction-fetch port (if_*),
// the load/store port (dm_*) and the single-ported memory (mem_*).
//   slave  : view taken by the arbiter (requests and mem_rdata in; grants, responses, mem_* out).
//   master : view taken by the surrounding logic / memory model (the mirror image).
// AW must match the AW of the mem_port_arbiter instance it is connected to.
interface mem_port_arbiter_if #(
   parameter int unsigned AW = 32
) ();

   // Instruction-fetch port
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [31:0]   if_rdata;

   // Load/store port
   logic          dm_req;
   logic          dm_we;
   logic [1:0]    dm_size;
   logic [AW-1:0] dm_addr;
   logic [31:0]   dm_wdata;
   logic          dm_gnt;
   logic          dm_rvalid;
   logic [31:0]   dm_rdata;
   logic          dm_err;

   // Memory side
   logic          mem_en;
   logic          mem_we;
   logic [1:0]    mem_size;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  dm_req, dm_we, dm_size, dm_addr, dm_wdata,
      output dm_gnt, dm_rvalid, dm_rdata, dm_err,
      output mem_en, mem_we, mem_size, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output dm_req, dm_we, dm_size, dm_addr, dm_wdata,
      input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
      input  mem_en, mem_we, mem_size, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous memory (1-cycle read latency)
// between the instruction-fetch port and the load/store port.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous, active-high reset; forces every output to 0 while asserted
//   bus  - mem_port_arbiter_if.slave: if_* fetch port, dm_* load/store port, mem_* memory
// Grants and the mem_* strobe are combinational from the requests; the owner of the
// in-flight access is registered and steers the next cycle's mem_rdata to the right port.
// DM is favoured on a tie unless IF has already waited through STARVE_LIMIT DM grants.
module mem_port_arbiter #(
   parameter int unsigned AW           = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_port_arbiter_if.slave     bus
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {
      OWN_NONE,
      OWN_IF,
      OWN_DM_RD,
      OWN_DM_WR,
      OWN_DM_ERR
   } owner_e;

   owner_e        owner_q, owner_d;
   logic [SW-1:0] starve_q, starve_d;

   logic dm_misaligned_c;
   logic starved_c;
   logic if_win_c;
   logic dm_win_c;

   // Fetch addresses are always word aligned; the low bits are deliberately dropped.
   logic unused_if_addr_lsbs;
   assign unused_if_addr_lsbs = ^bus.if_addr[1:0];

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q  <= OWN_NONE;
         starve_q <= '0;
      end else begin
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

   // Misalignment: half needs addr[0]=0, word (and the 11 encoding) needs addr[1:0]=0
   always_comb begin
      dm_misaligned_c = 1'b0;
      case (bus.dm_size)
         2'b00:   dm_misaligned_c = 1'b0;
         2'b01:   dm_misaligned_c = bus.dm_addr[0];
         default: dm_misaligned_c = |bus.dm_addr[1:0];
      endcase
   end

   // Arbitration: DM wins ties unless IF has been starved up to the limit
   always_comb begin
      starved_c = (starve_q == SW'(STARVE_LIMIT));
      if_win_c  = !rst && bus.if_req && (!bus.dm_req || starved_c);
      dm_win_c  = !rst && bus.dm_req && !if_win_c;
   end

   // Issue decision, memory drive and next owner / starvation count
   always_comb begin
      owner_d       = OWN_NONE;
      starve_d      = starve_q;
      bus.if_gnt    = 1'b0;
      bus.dm_gnt    = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_size  = 2'b00;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;

      if (if_win_c) begin
         bus.if_gnt   = 1'b1;
         bus.mem_en   = 1'b1;
         bus.mem_size = 2'b10;
         bus.mem_addr = {bus.if_addr[AW-1:2], 2'b00};
         owner_d      = OWN_IF;
      end else if (dm_win_c) begin
         bus.dm_gnt = 1'b1;
         // A misaligned access consumes the slot without touching memory
         if (dm_misaligned_c) begin
            owner_d = OWN_DM_ERR;
         end else begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.dm_we;
            bus.mem_size  = (bus.dm_size == 2'b11) ? 2'b10 : bus.dm_size;
            bus.mem_addr  = bus.dm_addr;
            bus.mem_wdata = bus.dm_wdata;
            owner_d       = bus.dm_we ? OWN_DM_WR : OWN_DM_RD;
         end
      end

      // Count DM grants that IF sat through; any IF grant or idle IF clears it
      if (!bus.if_req || if_win_c) begin
         starve_d = '0;
      end else if (dm_win_c && !starved_c) begin
         starve_d = starve_q + SW'(1);
      end
   end

   // Response routing; the reset gate also kills a response left in flight
   always_comb begin
      bus.if_rvalid = 1'b0;
      bus.if_rdata  = '0;
      bus.dm_rvalid = 1'b0;
      bus.dm_rdata  = '0;
      bus.dm_err    = 1'b0;
      if (!rst) begin
         case (owner_q)
            OWN_IF: begin
               bus.if_rvalid = 1'b1;
               bus.if_rdata  = bus.mem_rdata;
            end
            OWN_DM_RD: begin
               bus.dm_rvalid = 1'b1;
               bus.dm_rdata  = bus.mem_rdata;
            end
            OWN_DM_WR:  bus.dm_rvalid = 1'b1;
            OWN_DM_ERR: bus.dm_err    = 1'b1;
            default:    ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a small synchronous memory model serves the
// arbiter; each scenario task checks grants and the memory bus inline and pushes the
// response it expects into a scoreboard, which a response monitor pops and compares.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int K_IF  = 0;
   localparam int K_RD  = 1;
   localparam int K_WR  = 2;
   localparam int K_ERR = 3;

   typedef struct {
      int          kind;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic clk;
   logic rst;
   logic mem_init;
   int   cyc;
   int   checks;
   int   errors;
   exp_t sb[$];

   logic [31:0] mem_arr [0:255];
   logic [7:0]  m_idx;

   mem_port_arbiter_if #(.AW(AW)) bus ();

   mem_port_arbiter #(.AW(AW), .STARVE_LIMIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] pat(input logic [7:0] w);
      return {w ^ 8'hC3, w, ~w, 8'h5A};
   endfunction

   // Synchronous memory model with byte/half/word writes
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= pat(8'(i));
      end else if (bus.mem_en) begin
         m_idx = bus.mem_addr[9:2];
         if (bus.mem_we) begin
            case (bus.mem_size)
               2'b00:   mem_arr[m_idx][{bus.mem_addr[1:0], 3'b000} +: 8] <= bus.mem_wdata[7:0];
               2'b01:   mem_arr[m_idx][{bus.mem_addr[1], 4'b0000} +: 16] <= bus.mem_wdata[15:0];
               default: mem_arr[m_idx] <= bus.mem_wdata;
            endcase
         end else begin
            bus.mem_rdata <= mem_arr[m_idx];
         end
      end
   end

   // Response monitor: pops the scoreboard whenever the DUT responds
   always @(negedge clk) begin
      exp_t        e;
      logic [2:0]  exp_flags;
      logic [2:0]  obs_flags;
      logic [31:0] obs_data;
      #2;
      while (sb.size() > 0 && sb[0].due < cyc) begin
         checks++;
         errors++;
         $display("FAIL missing_resp cyc=%0d kind=%0d due=%0d", cyc, sb[0].kind, sb[0].due);
         sb.delete(0);
      end
      obs_flags = {bus.if_rvalid, bus.dm_rvalid, bus.dm_err};
      if (obs_flags != 3'b000) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp cyc=%0d flags=%b required=000", cyc, obs_flags);
         end else begin
            e = sb.pop_front();
            case (e.kind)
               K_IF:    exp_flags = 3'b100;
               K_ERR:   exp_flags = 3'b001;
               default: exp_flags = 3'b010;
            endcase
            obs_data = (e.kind == K_IF) ? bus.if_rdata : bus.dm_rdata;
            if (obs_flags !== exp_flags || obs_data !== e.data || e.due != cyc) begin
               errors++;
               $display("FAIL resp cyc=%0d kind=%0d flags=%b data=%h required flags=%b data=%h due=%0d",
                        cyc, e.kind, obs_flags, obs_data, exp_flags, e.data, e.due);
            end
         end
      end
      checks++;
      if ((!bus.if_rvalid && bus.if_rdata !== 32'h0) || (!bus.dm_rvalid && bus.dm_rdata !== 32'h0)) begin
         errors++;
         $display("FAIL rdata_idle cyc=%0d if_rdata=%h dm_rdata=%h required 0", cyc, bus.if_rdata, bus.dm_rdata);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic push(input int kind, input logic [31:0] data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      e.due  = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic set_idle();
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.dm_req   = 1'b0;
      bus.dm_we    = 1'b0;
      bus.dm_size  = 2'b00;
      bus.dm_addr  = '0;
      bus.dm_wdata = '0;
   endtask

   task automatic set_dm(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
      bus.dm_req   = 1'b1;
      bus.dm_we    = we;
      bus.dm_size  = size;
      bus.dm_addr  = addr;
      bus.dm_wdata = wdata;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         rst = 1'b1;
         bus.if_req = 1'b1;
         set_dm(1'b0, 2'b10, 32'h0, 32'h0);
         #1;
         checks++;
         if ({bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.if_rvalid, bus.dm_rvalid, bus.dm_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b%b en=%b valid=%b%b%b required all 0", bus.if_gnt,
                     bus.dm_gnt, bus.mem_en, bus.if_rvalid, bus.dm_rvalid, bus.dm_err);
         end
      end
      mem_init = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      set_idle();
      #1;
      checks++;
      if ({bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we} !== 4'b0 || bus.mem_addr !== 32'h0 ||
          bus.mem_size !== 2'b00 || bus.mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL idle_bus en=%b addr=%h size=%b wdata=%h required all 0", bus.mem_en,
                  bus.mem_addr, bus.mem_size, bus.mem_wdata);
      end
   endtask

   task automatic test_if_stream();
      logic [31:0] addrs [4];
      addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'hE;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.if_req  = 1'b1;
         bus.if_addr = addrs[i];
         #1;
         checks++;
         if ({bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we} !== 4'b1010 ||
             bus.mem_addr !== {addrs[i][31:2], 2'b00} || bus.mem_size !== 2'b10) begin
            errors++;
            $display("FAIL if_issue i=%0d gnt=%b%b en=%b we=%b addr=%h size=%b required 1010 addr=%h size=10",
                     i, bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_size,
                     {addrs[i][31:2], 2'b00});
         end
         push(K_IF, pat(addrs[i][9:2]));
      end
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_tie();
      @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h200;
      set_dm(1'b0, 2'b10, 32'h100, 32'h0);
      #1;
      checks++;
      if ({bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we} !== 4'b0110 || bus.mem_addr !== 32'h100 ||
          bus.mem_size !== 2'b10) begin
         errors++;
         $display("FAIL tie_dm gnt=%b%b en=%b we=%b addr=%h required 0110 addr=00000100",
                  bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
      end
      push(K_RD, pat(8'h40));
      @(negedge clk);
      bus.dm_req = 1'b0;
      #1;
      checks++;
      if ({bus.if_gnt, bus.dm_gnt, bus.mem_en} !== 3'b101 || bus.mem_addr !== 32'h200) begin
         errors++;
         $display("FAIL tie_if gnt=%b%b en=%b addr=%h required 101 addr=00000200",
                  bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_addr);
      end
      push(K_IF, pat(8'h80));
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_starve();
      logic exp_if;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         bus.if_req  = 1'b1;
         bus.if_addr = 32'h20;
         set_dm(1'b0, 2'b10, 32'h10, 32'h0);
         #1;
         exp_if = ((k % 5) == 4);
         checks++;
         if ({bus.if_gnt, bus.dm_gnt} !== {exp_if, !exp_if}) begin
            errors++;
            $display("FAIL starve k=%0d gnt=%b%b required %b%b", k, bus.if_gnt, bus.dm_gnt,
                     exp_if, !exp_if);
         end
         if (exp_if) push(K_IF, pat(8'h08));
         else        push(K_RD, pat(8'h04));
      end
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_store();
      logic [31:0] w;
      @(negedge clk);
      set_dm(1'b1, 2'b00, 32'h103, 32'h123456AB);
      #1;
      checks++;
      if ({bus.dm_gnt, bus.mem_en, bus.mem_we} !== 3'b111 || bus.mem_size !== 2'b00 ||
          bus.mem_addr !== 32'h103 || bus.mem_wdata !== 32'h123456AB) begin
         errors++;
         $display("FAIL store_byte gnt=%b en=%b we=%b size=%b addr=%h wdata=%h required 111 00 00000103 123456ab",
                  bus.dm_gnt, bus.mem_en, bus.mem_we, bus.mem_size, bus.mem_addr, bus.mem_wdata);
      end
      push(K_WR, 32'h0);
      @(negedge clk);
      set_dm(1'b1, 2'b01, 32'h106, 32'h0000BEEF);
      #1;
      checks++;
      if ({bus.dm_gnt, bus.mem_en, bus.mem_we} !== 3'b111 || bus.mem_size !== 2'b01 ||
          bus.mem_addr !== 32'h106) begin
         errors++;
         $display("FAIL store_half gnt=%b en=%b we=%b size=%b addr=%h required 111 01 00000106",
                  bus.dm_gnt, bus.mem_en, bus.mem_we, bus.mem_size, bus.mem_addr);
      end
      push(K_WR, 32'h0);
      @(negedge clk);
      set_dm(1'b0, 2'b10, 32'h100, 32'h0);
      #1;
      checks++;
      if ({bus.dm_gnt, bus.mem_en, bus.mem_we} !== 3'b110) begin
         errors++;
         $display("FAIL reload_issue gnt=%b en=%b we=%b required 110", bus.dm_gnt, bus.mem_en, bus.mem_we);
      end
      w = pat(8'h40);
      push(K_RD, {8'hAB, w[23:0]});
      @(negedge clk);
      set_dm(1'b0, 2'b10, 32'h104, 32'h0);
      w = pat(8'h41);
      push(K_RD, {16'hBEEF, w[15:0]});
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_misaligned();
      logic        we  [4];
      logic [1:0]  sz  [4];
      logic [31:0] ad  [4];
      logic [31:0] w;
      we[0] = 1'b0; sz[0] = 2'b10; ad[0] = 32'h102;
      we[1] = 1'b0; sz[1] = 2'b01; ad[1] = 32'h101;
      we[2] = 1'b1; sz[2] = 2'b01; ad[2] = 32'h103;
      we[3] = 1'b0; sz[3] = 2'b11; ad[3] = 32'h10A;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.if_req  = 1'b1;
         bus.if_addr = 32'h300;
         set_dm(we[i], sz[i], ad[i], 32'h0000DEAD);
         #1;
         checks++;
         if ({bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we} !== 4'b0100) begin
            errors++;
            $display("FAIL misaligned i=%0d gnt=%b%b en=%b we=%b required 0100", i, bus.if_gnt,
                     bus.dm_gnt, bus.mem_en, bus.mem_we);
         end
         push(K_ERR, 32'h0);
      end
      // Four rejected DM grants still starve IF, so IF takes the next slot
      @(negedge clk);
      set_dm(1'b0, 2'b11, 32'h10C, 32'h0);
      #1;
      checks++;
      if ({bus.if_gnt, bus.dm_gnt, bus.mem_en} !== 3'b101 || bus.mem_addr !== 32'h300) begin
         errors++;
         $display("FAIL err_starve gnt=%b%b en=%b addr=%h required 101 addr=00000300", bus.if_gnt,
                  bus.dm_gnt, bus.mem_en, bus.mem_addr);
      end
      push(K_IF, pat(8'hC0));
      @(negedge clk);
      bus.if_req = 1'b0;
      #1;
      checks++;
      if ({bus.dm_gnt, bus.mem_en, bus.mem_we} !== 3'b110 || bus.mem_addr !== 32'h10C) begin
         errors++;
         $display("FAIL size11_issue gnt=%b en=%b we=%b addr=%h required 110 addr=0000010c",
                  bus.dm_gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
      end
      push(K_RD, pat(8'h43));
      @(negedge clk);
      set_dm(1'b0, 2'b10, 32'h100, 32'h0);
      w = pat(8'h40);
      push(K_RD, {8'hAB, w[23:0]});
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_reset_inflight();
      @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h40;
      #1;
      checks++;
      if (bus.if_gnt !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_if gnt=%b required 1", bus.if_gnt);
      end
      @(negedge clk);
      rst = 1'b1;
      bus.if_req = 1'b0;
      #1;
      checks++;
      if ({bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid, bus.dm_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_kill_if gnt=%b%b valid=%b%b%b required 00000", bus.if_gnt, bus.dm_gnt,
                  bus.if_rvalid, bus.dm_rvalid, bus.dm_err);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         rst = 1'b0;
         bus.if_req  = 1'b1;
         bus.if_addr = 32'h20;
         set_dm(1'b0, 2'b10, 32'h10, 32'h0);
         #1;
         checks++;
         if ({bus.if_gnt, bus.dm_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL fill_starve k=%0d gnt=%b%b required 01", k, bus.if_gnt, bus.dm_gnt);
         end
         if (k < 3) push(K_RD, pat(8'h04));
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.if_rvalid, bus.dm_rvalid, bus.dm_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_kill_dm gnt=%b%b en=%b valid=%b%b%b required 000000", bus.if_gnt,
                  bus.dm_gnt, bus.mem_en, bus.if_rvalid, bus.dm_rvalid, bus.dm_err);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.if_gnt, bus.dm_gnt} !== 2'b01) begin
         errors++;
         $display("FAIL post_reset_tie gnt=%b%b required 01", bus.if_gnt, bus.dm_gnt);
      end
      push(K_RD, pat(8'h04));
      @(negedge clk);
      bus.dm_req = 1'b0;
      #1;
      checks++;
      if ({bus.if_gnt, bus.dm_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL post_reset_if gnt=%b%b required 10", bus.if_gnt, bus.dm_gnt);
      end
      push(K_IF, pat(8'h08));
      @(negedge clk);
      set_idle();
   endtask

   initial begin
      cyc      = 0;
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      mem_init = 1'b1;
      set_idle();
      test_reset();
      test_if_stream();
      test_tie();
      test_starve();
      test_store();
      test_misaligned();
      test_reset_inflight();
      repeat (3) begin
         @(negedge clk);
         set_idle();
      end
      #3;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
